// File: rtl/dp_request_fifo.sv
// dp_request_fifo: request buffer in front of one memory controller lane.
// Strict FIFO with occupancy, almost-full warning and sticky error flags.
module dp_request_fifo #(
   parameter int DATA_WIDTH        = 80,
   parameter int ADDR_BITS         = 4,
   parameter int ALMOST_FULL_LEVEL = 14
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  full,
   output logic                  almost_full,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  empty,
   output logic [ADDR_BITS:0]    count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   localparam logic [ADDR_BITS:0] CNT_FULL =
      {1'b1, {ADDR_BITS{1'b0}}};
   localparam logic [ADDR_BITS:0] CNT_AF =
      ALMOST_FULL_LEVEL[ADDR_BITS:0];
   localparam logic [ADDR_BITS:0] CNT_ONE =
      {{ADDR_BITS{1'b0}}, 1'b1};
   localparam logic [ADDR_BITS-1:0] PTR_ONE =
      {{(ADDR_BITS-1){1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_BITS-1:0]  wp;
   logic [ADDR_BITS-1:0]  rp;
   logic                  wr_acc;
   logic                  rd_acc;

   // Status flags decode only the registered occupancy, never the inputs
   always_comb begin
      full        = (count == CNT_FULL);
      empty       = (count == '0);
      almost_full = (count >= CNT_AF);
      wr_acc      = wr_en & ~full;
      rd_acc      = rd_en & ~empty;
   end

   // Storage array is not reset; only accepted writes touch it
   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wp] <= data_in;
   end

   // Write pointer advances on each accepted push, wrapping modulo depth
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         wp <= '0;
      else if (wr_acc)
         wp <= wp + PTR_ONE;
   end

   // Read pointer and output register advance on each accepted pop
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rp       <= '0;
         data_out <= '0;
      end else if (rd_acc) begin
         rp       <= rp + PTR_ONE;
         data_out <= mem[rp];
      end
   end

   // Occupancy is tracked separately so a full buffer is distinguishable
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else begin
         unique case ({wr_acc, rd_acc})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Sticky error flags; a clear request wins over a new error
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (err_clr) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en & full)
            overflow <= 1'b1;
         if (rd_en & empty)
            underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dp_request_fifo.sv
// tb_dp_request_fifo: directed stimulus with a queue-based scoreboard.
// Read data is checked by a monitor decoupled from the stimulus driver.
module tb_dp_request_fifo;

   logic        clk;
   logic        reset;
   logic        wr_en;
   logic [79:0] data_in;
   logic        full;
   logic        almost_full;
   logic        rd_en;
   logic [79:0] data_out;
   logic        empty;
   logic [4:0]  count;
   logic        overflow;
   logic        underflow;
   logic        err_clr;

   int n_cmp = 0;
   int n_bad = 0;

   logic [79:0] mq[$];
   logic [79:0] exp_q[$];
   logic [79:0] mdout;
   bit          movf;
   bit          munf;

   dp_request_fifo #(
      .DATA_WIDTH(80),
      .ADDR_BITS(4),
      .ALMOST_FULL_LEVEL(14)
   ) dut (
      .clk(clk),
      .reset(reset),
      .wr_en(wr_en),
      .data_in(data_in),
      .full(full),
      .almost_full(almost_full),
      .rd_en(rd_en),
      .data_out(data_out),
      .empty(empty),
      .count(count),
      .overflow(overflow),
      .underflow(underflow),
      .err_clr(err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [79:0] act,
                      input logic [79:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Monitor: one expected word per accepted read, checked after the edge
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         logic [79:0] e;
         e = exp_q.pop_front();
         chk("rd_data", data_out, e);
      end
   end

   task automatic status();
      int n;
      n = mq.size();
      chk("count", 80'(count), 80'(n));
      chk("empty", 80'(empty), 80'(n == 0));
      chk("full", 80'(full), 80'(n == 16));
      chk("almost_full", 80'(almost_full), 80'(n >= 14));
      chk("overflow", 80'(overflow), 80'(movf));
      chk("underflow", 80'(underflow), 80'(munf));
      chk("data_out", data_out, mdout);
   endtask

   task automatic cycle(input logic w, input logic [79:0] d,
                        input logic r, input logic c);
      bit wa;
      bit ra;
      wr_en   = w;
      data_in = d;
      rd_en   = r;
      err_clr = c;
      wa = w && (mq.size() < 16);
      ra = r && (mq.size() > 0);
      if (c) begin
         movf = 0;
         munf = 0;
      end else begin
         if (w && mq.size() == 16) movf = 1;
         if (r && mq.size() == 0) munf = 1;
      end
      if (ra) begin
         mdout = mq.pop_front();
         exp_q.push_back(mdout);
      end
      if (wa) mq.push_back(d);
      @(posedge clk);
      @(negedge clk);
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      err_clr = 1'b0;
      status();
   endtask

   task automatic model_reset();
      mq.delete();
      mdout = '0;
      movf  = 0;
      munf  = 0;
   endtask

   initial begin
      reset   = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      err_clr = 1'b0;
      data_in = '0;
      model_reset();

      // reset held low while pushing: nothing must be accepted
      @(negedge clk);
      wr_en   = 1'b1;
      data_in = 80'hAAAA;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_empty", 80'(empty), 80'd1);
      chk("rst_count", 80'(count), 80'd0);
      chk("rst_full", 80'(full), 80'd0);
      chk("rst_ovf", 80'(overflow), 80'd0);
      chk("rst_dout", data_out, 80'd0);
      wr_en = 1'b0;
      reset = 1'b1;

      // first write after release
      cycle(1, 80'h1, 0, 0);
      chk("first_cnt", 80'(count), 80'd1);
      chk("first_empty", 80'(empty), 80'd0);
      cycle(0, '0, 1, 0);

      // fill and drain
      for (int i = 0; i < 16; i++) cycle(1, 80'(i), 0, 0);
      chk("fill_full", 80'(full), 80'd1);
      for (int i = 0; i < 16; i++) cycle(0, '0, 1, 0);
      chk("drain_dout", data_out, 80'd15);
      chk("drain_empty", 80'(empty), 80'd1);

      // wrap-around across the pointer boundary
      for (int i = 0; i < 10; i++) cycle(1, 80'(100 + i), 0, 0);
      for (int i = 0; i < 10; i++) cycle(0, '0, 1, 0);
      for (int i = 0; i < 16; i++) cycle(1, 80'(200 + i), 0, 0);
      for (int i = 0; i < 16; i++) cycle(0, '0, 1, 0);
      chk("wrap_cnt", 80'(count), 80'd0);

      // simultaneous read/write at count 5
      for (int i = 0; i < 5; i++) cycle(1, 80'(300 + i), 0, 0);
      for (int i = 0; i < 8; i++) cycle(1, 80'(400 + i), 1, 0);
      chk("rw_cnt", 80'(count), 80'd5);
      for (int i = 0; i < 5; i++) cycle(0, '0, 1, 0);

      // full with both high: read taken, write dropped
      for (int i = 0; i < 16; i++) cycle(1, 80'(500 + i), 0, 0);
      cycle(1, 80'hDEAD, 1, 0);
      chk("fullrw_cnt", 80'(count), 80'd15);
      chk("fullrw_ovf", 80'(overflow), 80'd1);
      cycle(0, '0, 0, 1);
      cycle(1, 80'h600, 0, 0);
      cycle(1, 80'hBEEF, 0, 1);
      chk("clr_ovf", 80'(overflow), 80'd0);
      for (int i = 0; i < 16; i++) cycle(0, '0, 1, 0);

      // empty edge: write accepted, read rejected
      cycle(1, 80'h1234_5678_9ABC, 1, 0);
      chk("edge_cnt", 80'(count), 80'd1);
      chk("edge_unf", 80'(underflow), 80'd1);
      cycle(0, '0, 1, 0);
      chk("edge_dout", data_out, 80'h1234_5678_9ABC);
      cycle(0, '0, 0, 1);

      // asynchronous reset mid-stream
      for (int i = 0; i < 7; i++) cycle(1, 80'(700 + i), 0, 0);
      #2;
      reset = 1'b0;
      #1;
      chk("async_cnt", 80'(count), 80'd0);
      chk("async_empty", 80'(empty), 80'd1);
      chk("async_dout", data_out, 80'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      status();
      cycle(1, 80'h77, 0, 0);
      cycle(0, '0, 1, 0);

      chk("scoreboard_left", 80'(exp_q.size()), 80'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
